// File: rtl/mem_bus_ctrl.sv
// PicoRV32 native-port bus controller: decodes CPU requests onto an SRAM bank
// and one peripheral port, with error termination for unmapped/timed-out accesses.
module mem_bus_ctrl #(
  parameter int unsigned SRAM_AW   = 13,
  parameter logic [31:0] SRAM_BASE = 32'h0000_0000,
  parameter int unsigned PER_AW    = 8,
  parameter logic [31:0] PER_BASE  = 32'h8000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_valid,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  output logic                sram_sel,
  output logic [3:0]          sram_wstrb,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [31:0]         sram_wdata,
  input  logic                sram_ready,
  input  logic [31:0]         sram_rdata,
  output logic                per_sel,
  output logic [3:0]          per_wstrb,
  output logic [PER_AW-1:0]   per_addr,
  output logic [31:0]         per_wdata,
  input  logic                per_ready,
  input  logic [31:0]         per_rdata,
  output logic                bus_err,
  output logic [31:0]         err_addr,
  output logic [7:0]          err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SRAM = 2'd1;
  localparam logic [1:0] S_PER  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [15:0] TO_LIMIT = TIMEOUT[15:0];

  logic [1:0]          r_state;
  logic                r_first;
  logic [15:0]         r_cnt;
  logic [31:0]         r_addr;
  logic [3:0]          r_wstrb;
  logic                r_mem_ready;
  logic [31:0]         r_mem_rdata;
  logic                r_sram_sel;
  logic [3:0]          r_sram_wstrb;
  logic [SRAM_AW-1:0]  r_sram_addr;
  logic [31:0]         r_sram_wdata;
  logic                r_per_sel;
  logic [3:0]          r_per_wstrb;
  logic [PER_AW-1:0]   r_per_addr;
  logic [31:0]         r_per_wdata;
  logic                r_bus_err;
  logic [31:0]         r_err_addr;
  logic [7:0]          r_err_cnt;

  logic w_sram_hit;
  logic w_per_hit;
  logic [7:0] w_err_cnt_inc;

  assign w_sram_hit    = (mem_addr[31:SRAM_AW] == SRAM_BASE[31:SRAM_AW]);
  assign w_per_hit     = (mem_addr[31:PER_AW] == PER_BASE[31:PER_AW]);
  assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_first      <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wstrb      <= '0;
      r_mem_ready  <= 1'b0;
      r_mem_rdata  <= '0;
      r_sram_sel   <= 1'b0;
      r_sram_wstrb <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_per_sel    <= 1'b0;
      r_per_wstrb  <= '0;
      r_per_addr   <= '0;
      r_per_wdata  <= '0;
      r_bus_err    <= 1'b0;
      r_err_addr   <= '0;
      r_err_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_valid) begin
            r_addr  <= mem_addr;
            r_wstrb <= mem_wstrb;
            if (w_sram_hit) begin
              r_sram_sel   <= 1'b1;
              r_sram_wstrb <= mem_wstrb;
              r_sram_addr  <= mem_addr[SRAM_AW-1:0];
              r_sram_wdata <= mem_wdata;
              r_first      <= 1'b1;
              r_state      <= S_SRAM;
            end else if (w_per_hit) begin
              r_per_sel   <= 1'b1;
              r_per_wstrb <= mem_wstrb;
              r_per_addr  <= mem_addr[PER_AW-1:0];
              r_per_wdata <= mem_wdata;
              r_cnt       <= '0;
              r_state     <= S_PER;
            end else begin
              r_mem_rdata <= 32'hFFFF_FFFF;
              r_mem_ready <= 1'b1;
              r_bus_err   <= 1'b1;
              r_err_addr  <= mem_addr;
              r_err_cnt   <= w_err_cnt_inc;
              r_state     <= S_RESP;
            end
          end
        end
        S_SRAM: begin
          // first cycle's sram_ready still reflects the previous access
          r_first <= 1'b0;
          if (!r_first && sram_ready) begin
            r_mem_rdata  <= (r_wstrb == 4'd0) ? sram_rdata : '0;
            r_sram_sel   <= 1'b0;
            r_sram_wstrb <= '0;
            r_mem_ready  <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_PER: begin
          if (per_ready) begin
            r_mem_rdata <= (r_wstrb == 4'd0) ? per_rdata : '0;
            r_per_sel   <= 1'b0;
            r_per_wstrb <= '0;
            r_mem_ready <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt == TO_LIMIT) begin
            r_per_sel   <= 1'b0;
            r_per_wstrb <= '0;
            r_mem_rdata <= 32'hFFFF_FFFF;
            r_mem_ready <= 1'b1;
            r_bus_err   <= 1'b1;
            r_err_addr  <= r_addr;
            r_err_cnt   <= w_err_cnt_inc;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          r_mem_ready <= 1'b0;
          r_bus_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready  = r_mem_ready;
  assign mem_rdata  = r_mem_rdata;
  assign sram_sel   = r_sram_sel;
  assign sram_wstrb = r_sram_wstrb;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign per_sel    = r_per_sel;
  assign per_wstrb  = r_per_wstrb;
  assign per_addr   = r_per_addr;
  assign per_wdata  = r_per_wdata;
  assign bus_err    = r_bus_err;
  assign err_addr   = r_err_addr;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: driver pushes expectations from a
// behavioural address-map model, monitor checks every mem_ready response.
module tb_mem_bus_ctrl;

  localparam int AW  = 13;
  localparam int PAW = 8;
  localparam int TO  = 255;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            mem_valid = 1'b0;
  logic [31:0]     mem_addr = '0;
  logic [31:0]     mem_wdata = '0;
  logic [3:0]      mem_wstrb = '0;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic            sram_sel;
  logic [3:0]      sram_wstrb;
  logic [AW-1:0]   sram_addr;
  logic [31:0]     sram_wdata;
  logic            sram_ready = 1'b0;
  logic [31:0]     sram_rdata = '0;
  logic            per_sel;
  logic [3:0]      per_wstrb;
  logic [PAW-1:0]  per_addr;
  logic [31:0]     per_wdata;
  logic            per_ready = 1'b0;
  logic [31:0]     per_rdata = '0;
  logic            bus_err;
  logic [31:0]     err_addr;
  logic [7:0]      err_cnt;

  mem_bus_ctrl #(.SRAM_AW(AW), .SRAM_BASE(32'h0000_0000), .PER_AW(PAW),
                 .PER_BASE(32'h8000_0000), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sram_sel(sram_sel), .sram_wstrb(sram_wstrb), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
    .per_sel(per_sel), .per_wstrb(per_wstrb), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_ready(per_ready), .per_rdata(per_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: 1-cycle registered SRAM and a peripheral answering after per_d cycles
  logic [31:0] dev_mem [2048] = '{default: '0};
  always @(posedge clk) begin
    sram_ready <= sram_sel;
    if (sram_sel) begin
      for (int b = 0; b < 4; b++)
        if (sram_wstrb[b]) dev_mem[sram_addr[AW-1:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= dev_mem[sram_addr[AW-1:2]];
    end
  end

  int          per_d = 1;
  logic [31:0] per_val = '0;
  int          pcnt = 0;
  always @(posedge clk) begin
    per_rdata <= per_val;
    if (per_sel) begin
      pcnt      <= pcnt + 1;
      per_ready <= ((pcnt + 1) == per_d);
    end else begin
      pcnt      <= 0;
      per_ready <= 1'b0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;
    int          lat;
    int          kind;   // 0 sram, 1 peripheral, 2 unmapped
    int          issue;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [2048] = '{default: '0};
  logic [31:0] m_err_addr = '0;
  int          m_err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @cyc %0d", name, got, exp, cyc);
    end
  endtask

  // Monitor
  int ssel_n = 0;
  int psel_n = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      ssel_n = 0;
      psel_n = 0;
    end else begin
      if (sram_sel) begin
        ssel_n++;
        if (q.size() > 0) begin
          chk("sram_wstrb", {28'd0, sram_wstrb}, {28'd0, q[0].wstrb});
          chk("sram_addr", {19'd0, sram_addr}, {19'd0, q[0].addr[AW-1:0]});
        end
      end
      if (per_sel) begin
        psel_n++;
        if (q.size() > 0) begin
          chk("per_wstrb", {28'd0, per_wstrb}, {28'd0, q[0].wstrb});
          chk("per_addr", {24'd0, per_addr}, {24'd0, q[0].addr[PAW-1:0]});
        end
      end
      if (mem_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("mem_rdata", mem_rdata, e.rdata);
          chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
          chk("err_addr", err_addr, e.err_addr);
          chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.err_cnt});
          chk("latency", cyc - e.issue, e.lat);
          chk("sram_sel_cycles", ssel_n, (e.kind == 0) ? e.lat - 1 : 0);
          chk("per_sel_cycles", psel_n, (e.kind == 1) ? e.lat - 1 : 0);
        end
        ssel_n = 0;
        psel_n = 0;
      end
    end
  end

  // Driver + reference model; called at a negedge with the DUT idle
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input int d, input logic [31:0] pv);
    exp_t e;
    int   w;
    bit   done;
    e.addr = a; e.wstrb = ws; e.err = 1'b0;
    if (a[31:AW] == '0) begin
      e.kind = 0; e.lat = 3;
      w = int'(a[AW-1:2]);
      if (ws == 4'd0) e.rdata = ref_mem[w];
      else begin
        for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
        e.rdata = '0;
      end
    end else if (a[31:PAW] == 24'h80_0000) begin
      e.kind = 1;
      if (d <= TO) begin
        e.lat = d + 2;
        e.rdata = (ws == 4'd0) ? pv : 32'd0;
      end else begin
        e.lat = TO + 2;
        e.rdata = 32'hFFFF_FFFF;
        e.err = 1'b1;
      end
    end else begin
      e.kind = 2; e.lat = 1; e.rdata = 32'hFFFF_FFFF; e.err = 1'b1;
    end
    if (e.err) begin
      if (m_err_cnt < 255) m_err_cnt++;
      m_err_addr = a;
    end
    e.err_addr = m_err_addr;
    e.err_cnt  = 8'(m_err_cnt);
    per_d = d; per_val = pv;
    mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_valid = 1'b1;
    e.issue = cyc;
    q.push_back(e);
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (mem_ready) done = 1;
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    mem_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  ws;
    int          k;
    int          d;
    repeat (3) @(negedge clk);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_sram_sel", {31'd0, sram_sel}, 32'd0);
    chk("rst_per_sel", {31'd0, per_sel}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases from the address map and timing rules
    ref_mem[4] = 32'h1234_5678;
    dev_mem[4] = 32'h1234_5678;
    issue(32'h0000_0010, 32'h0, 4'b0000, 1, 32'h0);
    issue(32'h0000_0004, 32'hAABB_CCDD, 4'b0011, 1, 32'h0);
    issue(32'h0000_0004, 32'h0, 4'b0000, 1, 32'h0);
    issue(32'h8000_0020, 32'h0, 4'b0000, 5, 32'h0000_00A5);
    issue(32'h8000_0020, 32'h0, 4'b0000, 1000, 32'h0);
    issue(32'h8000_0020, 32'h0, 4'b0000, TO, 32'h5A5A_0001);
    issue(32'h4000_0000, 32'h0, 4'b0000, 1, 32'h0);
    issue(32'h0000_2000, 32'h0, 4'b0000, 1, 32'h0);
    issue(32'h8000_0100, 32'h0, 4'b0000, 1, 32'h0);

    // Randomised mix
    for (int n = 0; n < 200; n++) begin
      k  = $urandom_range(0, 9);
      ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      d  = $urandom_range(1, 12);
      if (k <= 5)      a = {19'd0, 7'($urandom_range(0, 127) >> ($urandom_range(0, 1) * 3)), 4'($urandom_range(0, 15) & 4'hC)} & 32'h0000_1FFC;
      else if (k <= 8) begin
        a = 32'h8000_0000 | 32'($urandom_range(0, 255));
        if ($urandom_range(0, 19) == 0) d = 300;
      end else         a = 32'h4000_0000 + 32'($urandom_range(0, 65535));
      issue(a, $urandom, ws, d, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Error counter saturation
    for (int n = 0; n < 300; n++) issue(32'h4000_0000 + 32'(n), 32'h0, 4'b0000, 1, 32'h0);

    // Reset in the middle of an SRAM access
    mem_addr = 32'h0000_0010; mem_wstrb = 4'b0000; mem_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_sram_sel", {31'd0, sram_sel}, 32'd1);
    reset = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_sram_sel", {31'd0, sram_sel}, 32'd0);
    chk("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    reset = 1'b0;
    m_err_cnt = 0; m_err_addr = '0;
    @(negedge clk);
    issue(32'h0000_0010, 32'h0, 4'b0000, 1, 32'h0);
    issue(32'h8000_0044, 32'h0, 4'b0000, 3, 32'hC0DE_0044);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Bus controller between the PicoRV32 native memory port and the on-chip SRAM bank plus one generic peripheral port.
- Decodes each CPU request and drives the SRAM select/strobe/address handshake.
- Waits on the SRAM's registered ready, returns read data, and pulses mem_ready to the CPU.
- Unmapped accesses and peripheral timeouts are terminated with an error response, so the CPU never hangs.

Parameters:
SRAM_AW, 13, SRAM byte-address width (8 KiB window)
SRAM_BASE, 32'h0000_0000, SRAM window base; bits [31:SRAM_AW] compared
PER_AW, 8, peripheral byte-address width (256 B window)
PER_BASE, 32'h8000_0000, peripheral window base; bits [31:PER_AW] compared
TIMEOUT, 255, max peripheral wait cycles before error (1..65535)

Ports:
clk  in  1  system clock; sole clock domain
reset  in  1  synchronous, active-high reset
mem_valid  in  1  CPU request valid; held until mem_ready
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  byte write enables; 0 = read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
sram_sel  out  1  SRAM select
sram_wstrb  out  4  SRAM byte write enables
sram_addr  out  SRAM_AW  SRAM byte address
sram_wdata  out  32  SRAM write data
sram_ready  in  1  SRAM ready (registered copy of sram_sel)
sram_rdata  in  32  SRAM read data
per_sel  out  1  peripheral select
per_wstrb  out  4  peripheral byte enables
per_addr  out  PER_AW  peripheral byte address
per_wdata  out  32  peripheral write data
per_ready  in  1  peripheral ready
per_rdata  in  32  peripheral read data
bus_err  out  1  one-cycle pulse on unmapped access or timeout
err_addr  out  32  address of the most recent error
err_cnt  out  8  saturating error count

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, timeout counter 0.
  - Reset asserted mid-transaction aborts it: sel lines drop at the next edge and no mem_ready is issued.
- All outputs are registered.
- States: IDLE, SRAM, PER, RESP.
- IDLE:
  - On mem_valid=1, latch addr/wdata/wstrb and decode. SRAM match takes priority over PER.
  - SRAM hit -> SRAM, with sram_sel=1 and strobes/addr/wdata driven from the latch.
  - PER hit -> PER, with per_sel=1 and counter=0.
  - No match -> RESP with mem_rdata=32'hFFFF_FFFF, bus_err=1, err_addr=addr, err_cnt+1 (saturates at 255).
- SRAM:
  - sram_ready is ignored in the first SRAM cycle; this masks a stale ready.
  - From the second cycle on, sram_ready=1 -> capture sram_rdata (0 for writes), sram_sel=0, go RESP.
- SRAM timing:
  - With the 1-cycle SRAM, mem_ready is high in the 3rd cycle after the accepting edge.
  - Accept edge N; sel visible N..N+1; capture at N+2; mem_ready during cycle N+2..N+3.
- sram_wstrb is held constant for the whole SRAM state.
  - The SRAM writes on every selected cycle; a repeated write of the same data is harmless.
- PER:
  - Hold per_sel. per_ready=1 -> capture per_rdata (0 for writes), go RESP.
  - Otherwise counter+1. When counter==TIMEOUT -> drop per_sel, RESP with rdata 32'hFFFF_FFFF and bus_err/err_addr/err_cnt update.
  - per_ready in the same cycle as the timeout wins (normal completion).
- RESP:
  - mem_ready=1 for exactly one cycle, then IDLE. All sel lines are 0.
  - RESP ignores mem_valid; IDLE always spends at least one cycle before accepting, which guarantees sram_ready has fallen.
- Back-to-back SRAM accesses: minimum 4 cycles per transaction.
- Address outputs: sram_addr = mem_addr[SRAM_AW-1:0]; per_addr = mem_addr[PER_AW-1:0]. Byte-lane alignment is the target's concern.
- mem_rdata holds its value outside RESP. The CPU must sample it only while mem_ready=1.

Test Plan:
- Read 0x0000_0010 with SRAM model returning 32'h1234_5678 -> sram_sel high 2 cycles, mem_ready high exactly 3 cycles after accept, mem_rdata=32'h1234_5678, bus_err=0.
- Write 0x0000_0004, wstrb=4'b0011, wdata=32'hAABB_CCDD, then read it back -> sram_wstrb=4'b0011 throughout SRAM state, read returns low half 16'hCCDD, one idle cycle between transactions.
- Peripheral read 0x8000_0020 with per_ready after 5 cycles, per_rdata=32'h0000_00A5 -> per_addr=8'h20, mem_rdata=32'hA5, no error.
- Peripheral never ready, TIMEOUT=255 -> per_sel drops after 256 cycles, mem_ready pulse, mem_rdata=32'hFFFF_FFFF, bus_err pulse, err_addr=32'h8000_0020, err_cnt=1.
- Access 0x4000_0000 -> no sel asserted, mem_ready on the 2nd cycle, bus_err=1, err_cnt increments; 300 such accesses -> err_cnt saturates at 255.
- reset asserted during SRAM state -> next cycle sram_sel=0, mem_ready=0, state IDLE; a following read completes normally.
